// File: rtl/lsu_pkg.sv
// Shared types and helpers for the LSU memory adapter: funct3 codes, FSM states,
// request legality/alignment and store lane placement.
package lsu_pkg;

  typedef enum logic [2:0] {
    F3_B  = 3'b000,
    F3_H  = 3'b001,
    F3_W  = 3'b010,
    F3_BU = 3'b100,
    F3_HU = 3'b101
  } funct3_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RSP   = 2'd3
  } state_e;

  // Legal funct3 for the direction and naturally aligned address.
  function automatic logic req_ok(input logic we, input logic [2:0] f3, input logic [1:0] a);
    case (f3)
      F3_B:    return 1'b1;
      F3_H:    return !a[0];
      F3_W:    return (a == 2'b00);
      F3_BU:   return !we;
      F3_HU:   return !we && !a[0];
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] store_mask(input logic [2:0] f3, input logic [1:0] a);
    case (f3[1:0])
      2'b00:   return 4'b0001 << a;
      2'b01:   return a[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] wd);
    case (f3[1:0])
      2'b00:   return {4{wd[7:0]}};
      2'b01:   return {2{wd[15:0]}};
      default: return wd;
    endcase
  endfunction

endpackage

// File: rtl/lsu_mem_adapter_if.sv
// Request, memory-port and response signals of the LSU adapter.
// slave is the adapter's view; master is the core/memory environment's view.
interface lsu_mem_adapter_if #(parameter int AW = 15);
  logic          t_req_valid;
  logic          t_req_ready;
  logic          t_req_we;
  logic [31:0]   t_req_addr;
  logic [2:0]    t_req_funct3;
  logic [31:0]   t_req_wdata;
  logic [4:0]    t_req_rd;
  logic          i_mem_valid;
  logic          i_mem_we;
  logic [AW-1:0] i_mem_addr;
  logic [31:0]   i_mem_data;
  logic [3:0]    i_mem_mask;
  logic          t_mem_valid;
  logic [31:0]   t_mem_data;
  logic          i_rsp_valid;
  logic          i_rsp_ready;
  logic [31:0]   i_rsp_data;
  logic [4:0]    i_rsp_rd;
  logic          i_rsp_err;

  modport slave (
    input  t_req_valid, t_req_we, t_req_addr, t_req_funct3, t_req_wdata, t_req_rd,
    output t_req_ready,
    output i_mem_valid, i_mem_we, i_mem_addr, i_mem_data, i_mem_mask,
    input  t_mem_valid, t_mem_data,
    output i_rsp_valid, i_rsp_data, i_rsp_rd, i_rsp_err,
    input  i_rsp_ready
  );

  modport master (
    output t_req_valid, t_req_we, t_req_addr, t_req_funct3, t_req_wdata, t_req_rd,
    input  t_req_ready,
    input  i_mem_valid, i_mem_we, i_mem_addr, i_mem_data, i_mem_mask,
    output t_mem_valid, t_mem_data,
    input  i_rsp_valid, i_rsp_data, i_rsp_rd, i_rsp_err,
    output i_rsp_ready
  );
endinterface

// File: rtl/lsu_load_align.sv
// Picks the byte/halfword addressed by addr_i out of a memory word and
// sign- or zero-extends it according to the load funct3.
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  addr_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] data_o
);
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = 8'h00;
    case (addr_i)
      2'd0: byte_sel = word_i[7:0];
      2'd1: byte_sel = word_i[15:8];
      2'd2: byte_sel = word_i[23:16];
      2'd3: byte_sel = word_i[31:24];
      default: byte_sel = 8'h00;
    endcase
    half_sel = addr_i[1] ? word_i[31:16] : word_i[15:0];
  end

  always_comb begin
    data_o = 32'h0;
    case (funct3_i)
      F3_B:    data_o = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   data_o = {24'h0, byte_sel};
      F3_H:    data_o = {{16{half_sel[15]}}, half_sel};
      F3_HU:   data_o = {16'h0, half_sel};
      F3_W:    data_o = word_i;
      default: data_o = 32'h0;
    endcase
  end
endmodule

// File: rtl/lsu_mem_adapter.sv
// Single-outstanding LSU to SRAM-style memory port adapter: checks the request,
// issues one lane-masked access and returns an extended load result or error.
module lsu_mem_adapter
  import lsu_pkg::*;
#(
  parameter int AW = 15
) (
  input  logic clk,
  input  logic rstf,
  lsu_mem_adapter_if.slave bus
);
  state_e        state_q;
  logic [1:0]    addr_lo_q;
  logic [2:0]    funct3_q;
  logic          we_q;
  logic          mem_valid_q;
  logic          mem_we_q;
  logic [AW-1:0] mem_addr_q;
  logic [31:0]   mem_data_q;
  logic [3:0]    mem_mask_q;
  logic          rsp_valid_q;
  logic [31:0]   rsp_data_q;
  logic [4:0]    rsp_rd_q;
  logic          rsp_err_q;
  logic [31:0]   load_data;
  logic          req_good;
  logic          unused_addr_hi;

  assign unused_addr_hi = ^bus.t_req_addr[31:AW];
  assign req_good = req_ok(bus.t_req_we, bus.t_req_funct3, bus.t_req_addr[1:0]);

  lsu_load_align u_align (
    .word_i   (bus.t_mem_data),
    .addr_i   (addr_lo_q),
    .funct3_i (funct3_q),
    .data_o   (load_data)
  );

  always_ff @(posedge clk or negedge rstf) begin
    if (!rstf) begin
      state_q     <= ST_IDLE;
      addr_lo_q   <= 2'b00;
      funct3_q    <= 3'b000;
      we_q        <= 1'b0;
      mem_valid_q <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_data_q  <= 32'h0;
      mem_mask_q  <= 4'h0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 32'h0;
      rsp_rd_q    <= 5'h0;
      rsp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.t_req_valid) begin
            addr_lo_q  <= bus.t_req_addr[1:0];
            funct3_q   <= bus.t_req_funct3;
            we_q       <= bus.t_req_we;
            rsp_rd_q   <= bus.t_req_rd;
            rsp_data_q <= 32'h0;
            rsp_err_q  <= !req_good;
            if (req_good) begin
              state_q     <= ST_ISSUE;
              mem_valid_q <= 1'b1;
              mem_we_q    <= bus.t_req_we;
              mem_addr_q  <= bus.t_req_addr[AW-1:0];
              mem_data_q  <= bus.t_req_we ? store_data(bus.t_req_funct3, bus.t_req_wdata) : 32'h0;
              mem_mask_q  <= bus.t_req_we ? store_mask(bus.t_req_funct3, bus.t_req_addr[1:0]) : 4'h0;
            end else begin
              // rejected requests never touch memory
              state_q     <= ST_RSP;
              rsp_valid_q <= 1'b1;
            end
          end
        end
        ST_ISSUE: begin
          mem_valid_q <= 1'b0;
          mem_we_q    <= 1'b0;
          mem_mask_q  <= 4'h0;
          if (we_q) begin
            state_q     <= ST_RSP;
            rsp_valid_q <= 1'b1;
          end else begin
            state_q <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (bus.t_mem_valid) begin
            state_q     <= ST_RSP;
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= load_data;
          end
        end
        ST_RSP: begin
          if (bus.i_rsp_ready) begin
            state_q     <= ST_IDLE;
            rsp_valid_q <= 1'b0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.t_req_ready = (state_q == ST_IDLE);
  assign bus.i_mem_valid = mem_valid_q;
  assign bus.i_mem_we    = mem_we_q;
  assign bus.i_mem_addr  = mem_addr_q;
  assign bus.i_mem_data  = mem_data_q;
  assign bus.i_mem_mask  = mem_mask_q;
  assign bus.i_rsp_valid = rsp_valid_q;
  assign bus.i_rsp_data  = rsp_data_q;
  assign bus.i_rsp_rd    = rsp_rd_q;
  assign bus.i_rsp_err   = rsp_err_q;
endmodule

// File: tb/tb_lsu_mem_adapter.sv
// Directed bench for lsu_mem_adapter: table of single transactions plus
// hand sequences for reset, stray memory data and reset during WAIT.
module tb_lsu_mem_adapter;
  logic clk = 1'b0;
  logic rstf;
  always #5 clk = ~clk;

  lsu_mem_adapter_if #(.AW(15)) bus ();
  lsu_mem_adapter #(.AW(15)) dut (.clk(clk), .rstf(rstf), .bus(bus));

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [2:0]  f3;
    logic [31:0] wdata;
    logic [31:0] mword;
    int          hold;
    logic        exp_mem;
    logic [3:0]  exp_mask;
    logic [31:0] exp_mdata;
    logic [14:0] exp_maddr;
    logic        exp_err;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vt[14];
  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_txn(input vec_t v, input int idx);
    logic [4:0]  rd;
    int          mem_cnt, rsp_k, exp_lat;
    logic        pend;
    logic [3:0]  c_mask;
    logic [31:0] c_data;
    logic [14:0] c_addr;
    logic        c_we;
    rd = 5'(idx + 3);
    mem_cnt = 0; rsp_k = -1; pend = 1'b0;
    c_mask = 4'h0; c_data = 32'h0; c_addr = 15'h0; c_we = 1'b0;
    exp_lat = !v.exp_mem ? 1 : (v.we ? 2 : 3);
    chk($sformatf("v%0d req_ready_idle", idx), {31'h0, bus.t_req_ready}, 32'h1);
    bus.t_req_valid = 1'b1; bus.t_req_we = v.we; bus.t_req_addr = v.addr;
    bus.t_req_funct3 = v.f3; bus.t_req_wdata = v.wdata; bus.t_req_rd = rd;
    bus.i_rsp_ready = (v.hold == 0);
    tick();
    bus.t_req_valid = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      bus.t_mem_valid = pend;
      bus.t_mem_data  = pend ? v.mword : 32'h5A5A_5A5A;
      pend = 1'b0;
      if (bus.i_mem_valid) begin
        mem_cnt++;
        c_mask = bus.i_mem_mask; c_data = bus.i_mem_data;
        c_addr = bus.i_mem_addr; c_we = bus.i_mem_we;
        pend = !v.we;
      end else begin
        chk($sformatf("v%0d mask_we_idle", idx), {27'h0, bus.i_mem_we, bus.i_mem_mask}, 32'h0);
      end
      if (bus.i_rsp_valid) begin
        rsp_k = k;
        break;
      end
      tick();
    end
    bus.t_mem_valid = 1'b0;
    if (rsp_k < 0) begin
      chk($sformatf("v%0d rsp_timeout", idx), 32'h0, 32'h1);
      return;
    end
    chk($sformatf("v%0d latency", idx), rsp_k, exp_lat);
    chk($sformatf("v%0d mem_count", idx), mem_cnt, {31'h0, v.exp_mem});
    if (v.exp_mem) begin
      chk($sformatf("v%0d mem_addr", idx), {17'h0, c_addr}, {17'h0, v.exp_maddr});
      chk($sformatf("v%0d mem_we", idx), {31'h0, c_we}, {31'h0, v.we});
      chk($sformatf("v%0d mem_mask", idx), {28'h0, c_mask}, {28'h0, v.exp_mask});
      if (v.we) chk($sformatf("v%0d mem_data", idx), c_data, v.exp_mdata);
    end
    chk($sformatf("v%0d rsp_err", idx), {31'h0, bus.i_rsp_err}, {31'h0, v.exp_err});
    chk($sformatf("v%0d rsp_data", idx), bus.i_rsp_data, v.exp_data);
    chk($sformatf("v%0d rsp_rd", idx), {27'h0, bus.i_rsp_rd}, {27'h0, rd});
    for (int h = 0; h < v.hold; h++) begin
      tick();
      chk($sformatf("v%0d hold_valid", idx), {31'h0, bus.i_rsp_valid}, 32'h1);
      chk($sformatf("v%0d hold_data", idx), bus.i_rsp_data, v.exp_data);
      chk($sformatf("v%0d hold_rd", idx), {27'h0, bus.i_rsp_rd}, {27'h0, rd});
      chk($sformatf("v%0d hold_req_ready", idx), {31'h0, bus.t_req_ready}, 32'h0);
    end
    bus.i_rsp_ready = 1'b1;
    tick();
    chk($sformatf("v%0d rsp_drop", idx), {31'h0, bus.i_rsp_valid}, 32'h0);
    chk($sformatf("v%0d back_idle", idx), {31'h0, bus.t_req_ready}, 32'h1);
  endtask

  initial begin
    //        we    addr          f3      wdata         mword         hold mem  mask    mdata         maddr       err   data
    vt[0]  = '{1'b1, 32'h0000_0104, 3'b010, 32'hDEAD_BEEF, 32'h0,        0, 1'b1, 4'b1111, 32'hDEAD_BEEF, 15'h0104, 1'b0, 32'h0};
    vt[1]  = '{1'b1, 32'h0000_0102, 3'b000, 32'h0000_00A5, 32'h0,        0, 1'b1, 4'b0100, 32'hA5A5_A5A5, 15'h0102, 1'b0, 32'h0};
    vt[2]  = '{1'b1, 32'h0000_0106, 3'b001, 32'h1234_ABCD, 32'h0,        0, 1'b1, 4'b1100, 32'hABCD_ABCD, 15'h0106, 1'b0, 32'h0};
    vt[3]  = '{1'b0, 32'h0000_0103, 3'b000, 32'h0,         32'h8011_2233, 0, 1'b1, 4'b0000, 32'h0,        15'h0103, 1'b0, 32'hFFFF_FF80};
    vt[4]  = '{1'b0, 32'h0000_0103, 3'b100, 32'h0,         32'h8011_2233, 0, 1'b1, 4'b0000, 32'h0,        15'h0103, 1'b0, 32'h0000_0080};
    vt[5]  = '{1'b0, 32'h0000_0101, 3'b001, 32'h0,         32'h8011_2233, 0, 1'b0, 4'b0000, 32'h0,        15'h0,    1'b1, 32'h0};
    vt[6]  = '{1'b0, 32'h0000_0100, 3'b011, 32'h0,         32'h8011_2233, 0, 1'b0, 4'b0000, 32'h0,        15'h0,    1'b1, 32'h0};
    vt[7]  = '{1'b0, 32'h0000_0102, 3'b001, 32'h0,         32'h8011_2233, 0, 1'b1, 4'b0000, 32'h0,        15'h0102, 1'b0, 32'hFFFF_8011};
    vt[8]  = '{1'b0, 32'h0000_0100, 3'b101, 32'h0,         32'h1234_F00D, 0, 1'b1, 4'b0000, 32'h0,        15'h0100, 1'b0, 32'h0000_F00D};
    vt[9]  = '{1'b0, 32'h8000_7FFC, 3'b010, 32'h0,         32'hCAFE_F00D, 5, 1'b1, 4'b0000, 32'h0,        15'h7FFC, 1'b0, 32'hCAFE_F00D};
    vt[10] = '{1'b1, 32'h0000_0102, 3'b010, 32'h1111_2222, 32'h0,        0, 1'b0, 4'b0000, 32'h0,        15'h0,    1'b1, 32'h0};
    vt[11] = '{1'b1, 32'h0000_0100, 3'b100, 32'h1111_2222, 32'h0,        0, 1'b0, 4'b0000, 32'h0,        15'h0,    1'b1, 32'h0};
    vt[12] = '{1'b0, 32'h0000_0100, 3'b000, 32'h0,         32'h0000_007F, 0, 1'b1, 4'b0000, 32'h0,        15'h0100, 1'b0, 32'h0000_007F};
    vt[13] = '{1'b1, 32'h0000_0101, 3'b000, 32'hFFFF_FF3C, 32'h0,        0, 1'b1, 4'b0010, 32'h3C3C_3C3C, 15'h0101, 1'b0, 32'h0};

    bus.t_req_valid = 1'b0; bus.t_req_we = 1'b0; bus.t_req_addr = 32'h0;
    bus.t_req_funct3 = 3'b0; bus.t_req_wdata = 32'h0; bus.t_req_rd = 5'h0;
    bus.t_mem_valid = 1'b0; bus.t_mem_data = 32'h0; bus.i_rsp_ready = 1'b1;
    rstf = 1'b0;
    tick(); tick();

    chk("reset mem_ctl", {26'h0, bus.i_mem_valid, bus.i_mem_we, bus.i_mem_mask}, 32'h0);
    chk("reset mem_addr", {17'h0, bus.i_mem_addr}, 32'h0);
    chk("reset mem_data", bus.i_mem_data, 32'h0);
    chk("reset rsp_ctl", {30'h0, bus.i_rsp_valid, bus.i_rsp_err}, 32'h0);
    chk("reset rsp_data", bus.i_rsp_data, 32'h0);
    chk("reset rsp_rd", {27'h0, bus.i_rsp_rd}, 32'h0);
    chk("reset req_ready", {31'h0, bus.t_req_ready}, 32'h1);
    rstf = 1'b1;
    tick();

    // stray memory data while idle must be ignored
    bus.t_mem_valid = 1'b1; bus.t_mem_data = 32'h1234_5678;
    tick(); tick();
    bus.t_mem_valid = 1'b0;
    tick();
    chk("stray rsp_valid", {31'h0, bus.i_rsp_valid}, 32'h0);
    chk("stray mem_valid", {31'h0, bus.i_mem_valid}, 32'h0);

    for (int i = 0; i < 14; i++) do_txn(vt[i], i);

    // reset while waiting for load data, then the data arrives late
    bus.t_req_valid = 1'b1; bus.t_req_we = 1'b0; bus.t_req_addr = 32'h0000_0200;
    bus.t_req_funct3 = 3'b010; bus.t_req_rd = 5'd9;
    tick();
    bus.t_req_valid = 1'b0;
    chk("rstwait mem_valid", {31'h0, bus.i_mem_valid}, 32'h1);
    tick();
    rstf = 1'b0;
    #1;
    chk("rstwait mem_valid_clr", {31'h0, bus.i_mem_valid}, 32'h0);
    chk("rstwait rsp_valid_clr", {31'h0, bus.i_rsp_valid}, 32'h0);
    tick();
    rstf = 1'b1;
    bus.t_mem_valid = 1'b1; bus.t_mem_data = 32'hBAD0_BAD0;
    tick();
    bus.t_mem_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      chk("rstwait no_rsp", {31'h0, bus.i_rsp_valid}, 32'h0);
      tick();
    end
    do_txn(vt[3], 20);
    do_txn(vt[0], 21);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/lsu_mem_adapter.md
LSU_MEM_ADAPTER -- requirements
Module: lsu_mem_adapter

Interface
REQ-001 Parameter AW, 15, byte-address width of the memory port (word depth 2^(AW-2)).
REQ-002 clk  input  1  sole clock, all state on rising edge.
REQ-003 rstf  input  1  reset, asynchronous, active-low.
REQ-004 t_req_valid  input  1  core load/store request valid.
REQ-005 t_req_ready  output  1  request accepted when valid&ready.
REQ-006 t_req_we  input  1  1=store, 0=load.
REQ-007 t_req_addr  input  32  byte address.
REQ-008 t_req_funct3  input  3  RV32I width/sign code.
REQ-009 t_req_wdata  input  32  store data, LSB-aligned.
REQ-010 t_req_rd  input  5  load destination register tag.
REQ-011 i_mem_valid, i_mem_we  output  1 each  memory port request, write enable.
REQ-012 i_mem_addr  output  AW  byte address to memory.
REQ-013 i_mem_data  output  32  lane-positioned write data.
REQ-014 i_mem_mask  output  4  byte-lane write mask.
REQ-015 t_mem_valid  input  1  memory read data valid, one cycle after a read request.
REQ-016 t_mem_data  input  32  memory read word.
REQ-017 i_rsp_valid  output  1  response valid.
REQ-018 i_rsp_ready  input  1  response consumed when valid&ready.
REQ-019 i_rsp_data  output  32  extended load result; 0 on error or store.
REQ-020 i_rsp_rd  output  5  tag of the request being answered.
REQ-021 i_rsp_err  output  1  misaligned or illegal funct3.

Function
REQ-022 FSM states IDLE, ISSUE, WAIT, RSP; t_req_ready=1 only in IDLE; one transaction in flight.
REQ-023 IDLE: on accept, register addr/funct3/wdata/rd/we; legal and aligned -> ISSUE; otherwise -> RSP with err=1 and no memory access.
REQ-024 Legal loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; legal stores: 000 SB, 001 SH, 010 SW; all other codes are illegal.
REQ-025 Misaligned: halfword with addr[0]=1; word with addr[1:0]!=0.
REQ-026 ISSUE: i_mem_valid=1 for exactly one cycle; i_mem_addr=addr[AW-1:0], upper bits ignored; store -> RSP (err=0, data=0), load -> WAIT.
REQ-027 Store lanes: SB mask=1<<addr[1:0], data={4{wdata[7:0]}}; SH mask=0011 (addr[1]=0) or 1100, data={2{wdata[15:0]}}; SW mask=1111, data=wdata.
REQ-028 i_mem_mask=0 and i_mem_we=0 whenever i_mem_valid=0 or the request is a load.
REQ-029 WAIT: on t_mem_valid, select the byte/halfword at addr[1:0], sign-extend (LB/LH) or zero-extend (LBU/LHU), load the response register, -> RSP.
REQ-030 RSP: i_rsp_valid=1 and outputs held stable until i_rsp_ready; on handshake -> IDLE, with no new request accepted in the same cycle.
REQ-031 t_mem_valid outside WAIT is ignored.
REQ-032 Load latency: accept cycle N, i_mem_valid at N+1, t_mem_valid at N+2, i_rsp_valid at N+3.

Reset
REQ-033 rstf low: state=IDLE and i_mem_valid, i_mem_we, i_mem_mask, i_rsp_valid, i_rsp_err=0; i_mem_addr, i_mem_data, i_rsp_data, i_rsp_rd=0.
REQ-034 Reset mid-transaction discards the transaction; a late t_mem_valid after reset produces no response.

Structure
REQ-035 Package lsu_pkg holds the funct3 enumeration, the FSM state enum and the misalignment/legality function.
REQ-036 Combinational sub-module lsu_load_align performs lane selection and extension (inputs: word, addr[1:0], funct3).

Verification
REQ-037 SW addr 0x104 data 0xDEADBEEF -> one i_mem_valid, mask 1111, addr 0x104, no response data, rsp err=0.
REQ-038 SB addr 0x102 data 0x000000A5 -> mask 0100, i_mem_data 0xA5A5A5A5.
REQ-039 LB addr 0x103 with memory word 0x80112233 -> rsp_data 0xFFFFFF80 at N+3; LBU at the same address -> 0x00000080.
REQ-040 LH addr 0x101 -> i_rsp_err=1, i_mem_valid never asserted, rsp_data 0; funct3 011 -> err=1.
REQ-041 LW with i_rsp_ready low for 5 cycles -> response stable and t_req_ready=0 throughout, then IDLE.
REQ-042 rstf asserted in WAIT, then memory returns data -> no i_rsp_valid, and the next request is served normally.
